// File: rtl/msd_pkg.sv
// Shared types and constants for the most-significant-decimal-digit extractor.
package msd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int BASE    = 10;
  localparam int DIGIT_W = 4;

endpackage

// File: rtl/div10_step.sv
// One combinational divide-by-ten step: quotient, 4-bit remainder and a below-ten flag.
module div10_step
  import msd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   quot,
  output logic [DIGIT_W-1:0] rem,
  output logic               lt10
);

  assign quot = din / WIDTH'(BASE);
  assign rem  = DIGIT_W'(din % WIDTH'(BASE));
  assign lt10 = (din < WIDTH'(BASE));

endmodule

// File: rtl/msd_extract_seq.sv
// Sequential MSD / digit-count extractor, one /10 step per clock with start/busy/done.
// Optional full BCD output is enabled by defining MSD_BCD_OUT_EN.
module msd_extract_seq
  import msd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             din,
  output logic                         busy,
  output logic                         done,
  output logic [DIGIT_W-1:0]           msd,
  output logic [$clog2(DIGITS+1)-1:0]  ndig
`ifdef MSD_BCD_OUT_EN
  ,
  output logic [DIGIT_W*DIGITS-1:0]    bcd
`endif
);

  localparam int NDW = $clog2(DIGITS+1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     work_q;
  logic [NDW-1:0]       cnt_q;
  logic [DIGIT_W-1:0]   msd_q, msd_d;
  logic [NDW-1:0]       ndig_q, ndig_d;

  logic [WIDTH-1:0]     quot;
  logic [DIGIT_W-1:0]   rem;
  logic                 lt10;
  logic                 run;
  logic                 accept;

  assign run    = (state_q == ST_RUN);
  assign accept = start && !run;

  div10_step #(.WIDTH(WIDTH)) u_div10 (
    .din  (work_q),
    .quot (quot),
    .rem  (rem),
    .lt10 (lt10)
  );

  // Once work < 10 the remainder equals work[3:0], so rem doubles as the final digit.
  always_comb begin
    state_d = state_q;
    msd_d   = msd_q;
    ndig_d  = ndig_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_RUN: begin
        if (lt10) begin
          state_d = ST_DONE;
          msd_d   = rem;
          ndig_d  = cnt_q + NDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      msd_q   <= '0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      msd_q   <= msd_d;
      ndig_q  <= ndig_d;
    end
  end

  // Working operand and step count need no reset; accept always reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_q <= din;
      cnt_q  <= '0;
    end else if (run && !lt10) begin
      work_q <= quot;
      cnt_q  <= cnt_q + NDW'(1);
    end
  end

`ifdef MSD_BCD_OUT_EN
  logic [DIGIT_W*DIGITS-1:0] shadow_q, shadow_d, bcd_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == NDW'(i)) begin
        shadow_d[DIGIT_W*i +: DIGIT_W] = rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_q <= '0;
    end else if (run) begin
      shadow_q <= shadow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
    end else if (run && lt10) begin
      bcd_q <= shadow_d;
    end
  end

  assign bcd = bcd_q;
`endif

  assign busy = run;
  assign done = (state_q == ST_DONE);
  assign msd  = msd_q;
  assign ndig = ndig_q;

endmodule

// File: tb/tb_msd_extract_seq.sv
// Self-checking bench for msd_extract_seq: decimal-string reference model plus directed cases.
module tb_msd_extract_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int NDW    = $clog2(DIGITS+1);
  localparam int BW     = 4*DIGITS;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [3:0]       msd;
  logic [NDW-1:0]   ndig;
`ifdef MSD_BCD_OUT_EN
  logic [BW-1:0]    bcd;
`endif

  msd_extract_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .msd   (msd),
    .ndig  (ndig)
`ifdef MSD_BCD_OUT_EN
    ,
    .bcd   (bcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: decimal text of the operand gives length, leading digit and BCD nibbles.
  function automatic void ref_calc(input int v, output int d, output int m, output logic [BW-1:0] b);
    string s;
    s = $sformatf("%0d", v);
    d = s.len();
    m = int'(s[0]) - 48;
    b = '0;
    for (int i = 0; i < d; i++) b[4*i +: 4] = 4'(int'(s[d-1-i]) - 48);
  endfunction

  int            cyc       = 0;
  bit            m_act     = 0;
  int            m_acc     = 0;
  int            m_d       = 0;
  int            m_done_at = -1;
  int            m_msd     = 0;
  int            m_ndig    = 0;
  logic [BW-1:0] m_bcd     = '0;
  int            p_msd     = 0;
  logic [BW-1:0] p_bcd     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act     = 0;
      m_done_at = -1;
      m_msd     = 0;
      m_ndig    = 0;
      m_bcd     = '0;
    end else begin
      bit busy_pre;
      cyc++;
      busy_pre = m_act && (cyc <= m_acc + m_d);
      if (m_act && cyc == m_acc + m_d) begin
        m_msd     = p_msd;
        m_ndig    = m_d;
        m_bcd     = p_bcd;
        m_act     = 0;
        m_done_at = cyc;
      end
      if (start && !busy_pre) begin
        m_act = 1;
        m_acc = cyc;
        ref_calc(int'(din), m_d, p_msd, p_bcd);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, (m_act && cyc < m_acc + m_d) ? 1 : 0);
      chk("done", done, (cyc == m_done_at) ? 1 : 0);
      chk("msd", msd, m_msd);
      chk("ndig", ndig, m_ndig);
`ifdef MSD_BCD_OUT_EN
      chk("bcd", bcd, m_bcd);
`endif
    end
  end

  task automatic start_now(input int v);
    din   = WIDTH'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input int v, input int e_msd, input int e_ndig);
    int lat;
    int nbusy;
    start_now(v);
    lat   = 0;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
    chk("latency", lat, e_ndig);
    chk("busy_cycles", nbusy, e_ndig);
    chk("op_msd", msd, e_msd);
    chk("op_ndig", ndig, e_ndig);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            d, m, pulses, seen_msd, seen_ndig;
    logic [BW-1:0] b;

    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    cmp_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_msd", msd, 0);
    chk("rst_ndig", ndig, 0);
    rst = 1'b0;
    @(negedge clk);

    ref_calc(65535, d, m, b);
    chk("model_65535_d", d, 5);
    chk("model_65535_m", m, 6);
    chk("model_65535_b", b, 20'h65535);
    ref_calc(0, d, m, b);
    chk("model_0_d", d, 1);
    chk("model_0_m", m, 0);
    ref_calc(40000, d, m, b);
    chk("model_40000_b", b, 20'h40000);

    // Zero operand
    run_op(0, 0, 1);
`ifdef MSD_BCD_OUT_EN
    chk("bcd_0", bcd, 20'h00000);
`endif

    // Single digit then back-to-back from DONE
    @(negedge clk);
    run_op(7, 7, 1);
    run_op(10, 1, 2);

    // Full-width operand
    @(negedge clk);
    run_op(65535, 6, 5);
`ifdef MSD_BCD_OUT_EN
    chk("bcd_65535", bcd, 20'h65535);
`endif

    // start during RUN is ignored
    @(negedge clk);
    start_now(40000);
    @(negedge clk);
    din   = WIDTH'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses    = 0;
    seen_msd  = -1;
    seen_ndig = -1;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        seen_msd  = int'(msd);
        seen_ndig = int'(ndig);
      end
      @(negedge clk);
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_msd", seen_msd, 4);
    chk("ignore_ndig", seen_ndig, 5);

    // Asynchronous reset mid-operation
    start_now(12345);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_msd", msd, 0);
    chk("arst_ndig", ndig, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_op(9, 9, 1);

    // Random sweep, including starts while busy
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 3 == 0);
      din   = WIDTH'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
